// File: rtl/vga_pkg.sv
// vga_pkg: VGA timing constants and the colour type shared by the video pipeline.
package vga_pkg;
    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int FONT_WIDTH = 8;
    localparam int BORDER_PX  = 5;
    typedef logic [2:0] rgb_t;
endpackage

// File: rtl/nibble_to_ascii.sv
// nibble_to_ascii: maps a hex nibble to its upper-case ASCII digit.
module nibble_to_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);
    always_comb ascii = (nibble < 4'd10) ? {4'h3, nibble} : {4'h0, nibble} + 8'h37;
endmodule

// File: rtl/hex_overlay.sv
// hex_overlay: hex value text overlay; syncs and rgb leave 4 px_clk after the inputs.
// Define HEX_OVERLAY_BORDER_EN to draw the frame border.
module hex_overlay
    import vga_pkg::*;
#(
    parameter int   DIGITS     = 4,
    parameter int   ZOOM       = 2,
    parameter int   COL        = 9,
    parameter int   ROW        = 8,
    parameter rgb_t FG         = 3'b010,
    parameter rgb_t BORDER_RGB = 3'b001
) (
    input  logic                  px_clk,
    input  logic                  resetn,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  activevideo_in,
    input  logic [9:0]            px_x_in,
    input  logic [9:0]            px_y_in,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  value_load,
    output logic                  value_busy,
    output logic [7:0]            font_char,
    output logic [9:0]            font_x,
    output logic [9:0]            font_y,
    input  logic                  font_bit,
    output logic                  hsync,
    output logic                  vsync,
    output rgb_t                  rgb
);
    localparam int SH = $clog2(FONT_WIDTH) + ZOOM;
    if (DIGITS < 1 || DIGITS > 8 || COL + DIGITS > (H_ACTIVE >> SH)) begin : g_bad_cfg
        $error("hex_overlay: DIGITS/COL do not fit the line at this ZOOM");
    end
    logic                s0_hs, s0_vs, s0_av, s1_hs, s1_vs, s1_av, s2_hs, s2_vs, s2_av, s2_bd;
    logic [9:0]          s0_x, s0_y, cx, cy, idx;
    logic [4*DIGITS-1:0] pending, shown, sh;
    logic [7:0]          ascii;
    logic                in_box, vs_fall;
    assign cx      = s0_x >> SH;
    assign cy      = s0_y >> SH;
    assign in_box  = s0_av && cy == 10'(ROW) && cx >= 10'(COL) && cx < 10'(COL + DIGITS);
    assign idx     = 10'(COL + DIGITS - 1) - cx;
    assign sh      = shown >> {idx, 2'b00};
    assign vs_fall = s0_vs & ~vsync_in;
    nibble_to_ascii u_n2a (.nibble(sh[3:0]), .ascii(ascii));
    // shown only changes on a vsync fall so a frame never shows a torn number
    always_ff @(posedge px_clk or negedge resetn) begin
        if (!resetn) begin
            pending    <= '0;
            shown      <= '0;
            value_busy <= 1'b0;
        end else begin
            if (vs_fall && value_busy) shown <= pending;
            if (value_load) begin
                pending    <= value;
                value_busy <= 1'b1;
            end else if (vs_fall) value_busy <= 1'b0;
        end
    end
    always_ff @(posedge px_clk or negedge resetn) begin
        if (!resetn) begin
            {s0_hs, s0_vs, s0_av} <= 3'b110;
            {s1_hs, s1_vs, s1_av} <= 3'b110;
            {s2_hs, s2_vs, s2_av} <= 3'b110;
            s0_x      <= '0;
            s0_y      <= '0;
            font_char <= '0;
            font_x    <= '0;
            font_y    <= '0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            rgb       <= '0;
        end else begin
            {s0_hs, s0_vs, s0_av} <= {hsync_in, vsync_in, activevideo_in};
            {s1_hs, s1_vs, s1_av} <= {s0_hs, s0_vs, s0_av};
            {s2_hs, s2_vs, s2_av} <= {s1_hs, s1_vs, s1_av};
            s0_x      <= px_x_in;
            s0_y      <= px_y_in;
            font_char <= in_box ? ascii : 8'h00;
            font_x    <= s0_x >> ZOOM;
            font_y    <= s0_y >> ZOOM;
            hsync     <= s2_hs;
            vsync     <= s2_vs;
            rgb       <= !s2_av ? '0 : font_bit ? FG : s2_bd ? BORDER_RGB : '0;
        end
    end
`ifdef HEX_OVERLAY_BORDER_EN
    logic s1_bd;
    always_ff @(posedge px_clk or negedge resetn) begin
        if (!resetn) {s1_bd, s2_bd} <= 2'b00;
        else begin
            s1_bd <= s0_x < 10'(BORDER_PX) || s0_x > 10'(H_ACTIVE - 1 - BORDER_PX) ||
                     s0_y < 10'(BORDER_PX) || s0_y > 10'(V_ACTIVE - 1 - BORDER_PX);
            s2_bd <= s1_bd;
        end
    end
`else
    assign s2_bd = 1'b0;
`endif
endmodule

// File: tb/tb_hex_overlay.sv
// tb_hex_overlay: directed table and sequence checks for hex_overlay with DIGITS=4, ZOOM=2.
module tb_hex_overlay;
    logic        px_clk = 1'b0, resetn = 1'b0;
    logic        hsync_in, vsync_in, activevideo_in, value_load, font_bit;
    logic [9:0]  px_x_in, px_y_in, font_x, font_y;
    logic [15:0] value;
    logic        value_busy, hsync, vsync;
    logic [7:0]  font_char;
    logic [2:0]  rgb;
    int          total = 0, bad = 0;
`ifdef HEX_OVERLAY_BORDER_EN
    localparam logic [2:0] BD = 3'b001;
`else
    localparam logic [2:0] BD = 3'b000;
`endif
    typedef struct {
        logic       hs, vs, av;
        logic [9:0] x, y;
        logic [7:0] ch;
        logic [2:0] rgb;
    } vec_t;
    localparam int N = 14;
    vec_t tv[N];
    hex_overlay dut (
        .px_clk(px_clk), .resetn(resetn), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .activevideo_in(activevideo_in), .px_x_in(px_x_in), .px_y_in(px_y_in),
        .value(value), .value_load(value_load), .value_busy(value_busy),
        .font_char(font_char), .font_x(font_x), .font_y(font_y), .font_bit(font_bit),
        .hsync(hsync), .vsync(vsync), .rgb(rgb)
    );
    always #5 px_clk = ~px_clk;
    // font model: one-cycle latency, glyph bit set only for x in 300..303
    always_ff @(posedge px_clk or negedge resetn)
        if (!resetn) font_bit <= 1'b0;
        else font_bit <= (font_x == 10'd75);
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic step();
        @(posedge px_clk);
        #1;
    endtask
    task automatic set(input logic hs, input logic vs, input logic av, input logic [9:0] x, input logic [9:0] y);
        hsync_in = hs; vsync_in = vs; activevideo_in = av; px_x_in = x; px_y_in = y;
    endtask
    initial begin
        tv[0]  = '{1'b1, 1'b1, 1'b1, 10'd290, 10'd260, 8'h42, 3'd0};
        tv[1]  = '{1'b0, 1'b1, 1'b1, 10'd320, 10'd260, 8'h45, 3'd0};
        tv[2]  = '{1'b1, 1'b1, 1'b1, 10'd352, 10'd260, 8'h45, 3'd0};
        tv[3]  = '{1'b1, 1'b0, 1'b1, 10'd384, 10'd260, 8'h46, 3'd0};
        tv[4]  = '{1'b1, 1'b1, 1'b1, 10'd416, 10'd260, 8'h00, 3'd0};
        tv[5]  = '{1'b1, 1'b1, 1'b1, 10'd290, 10'd250, 8'h00, 3'd0};
        tv[6]  = '{1'b1, 1'b1, 1'b0, 10'd290, 10'd260, 8'h00, 3'd0};
        tv[7]  = '{1'b0, 1'b1, 1'b1, 10'd300, 10'd260, 8'h42, 3'b010};
        tv[8]  = '{1'b1, 1'b1, 1'b0, 10'd300, 10'd260, 8'h00, 3'd0};
        tv[9]  = '{1'b1, 1'b1, 1'b1, 10'd2,   10'd100, 8'h00, BD};
        tv[10] = '{1'b1, 1'b1, 1'b1, 10'd637, 10'd470, 8'h00, BD};
        tv[11] = '{1'b0, 1'b0, 1'b1, 10'd100, 10'd477, 8'h00, BD};
        tv[12] = '{1'b1, 1'b1, 1'b1, 10'd5,   10'd5,   8'h00, 3'd0};
        tv[13] = '{1'b1, 1'b1, 1'b1, 10'd634, 10'd474, 8'h00, 3'd0};
        set(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
        value = '0; value_load = 1'b0;
        #12;
        chk("rst_hsync", hsync, 1); chk("rst_vsync", vsync, 1); chk("rst_rgb", rgb, 0);
        chk("rst_busy", value_busy, 0); chk("rst_char", font_char, 0);
        @(negedge px_clk) resetn = 1'b1;
        step(); step();
        value = 16'hBEEF; value_load = 1'b1; step(); value_load = 1'b0;
        chk("beef_busy", value_busy, 1);
        vsync_in = 1'b0; step(); vsync_in = 1'b1;
        chk("beef_busy_clr", value_busy, 0);
        step();
        for (int i = 0; i < N + 3; i++) begin
            if (i < N) set(tv[i].hs, tv[i].vs, tv[i].av, tv[i].x, tv[i].y);
            else set(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
            step();
            if (i >= 1 && i <= N) chk($sformatf("char[%0d]", i - 1), font_char, tv[i-1].ch);
            if (i >= 3) begin
                chk($sformatf("rgb[%0d]", i - 3), rgb, tv[i-3].rgb);
                chk($sformatf("hsync[%0d]", i - 3), hsync, tv[i-3].hs);
                chk($sformatf("vsync[%0d]", i - 3), vsync, tv[i-3].vs);
            end
        end
        value = 16'h1234; value_load = 1'b1; set(1'b1, 1'b1, 1'b1, 10'd290, 10'd260); step(); value_load = 1'b0;
        chk("mid_busy", value_busy, 1);
        set(1'b1, 1'b1, 1'b1, 10'd320, 10'd260); step();
        chk("mid_old_char0", font_char, 8'h42); chk("mid_busy2", value_busy, 1);
        step();
        chk("mid_old_char1", font_char, 8'h45);
        set(1'b1, 1'b0, 1'b1, 10'd290, 10'd260); step();
        chk("mid_busy_clr", value_busy, 0);
        set(1'b1, 1'b1, 1'b1, 10'd290, 10'd260); step();
        chk("mid_new_char0", font_char, 8'h31);
        set(1'b1, 1'b1, 1'b1, 10'd384, 10'd260); step(); step();
        chk("mid_new_char3", font_char, 8'h34);
        value = 16'h0001; value_load = 1'b1; step(); value_load = 1'b0;
        chk("sim_busy0", value_busy, 1);
        value = 16'h0002; value_load = 1'b1; vsync_in = 1'b0; step(); value_load = 1'b0; vsync_in = 1'b1;
        chk("sim_busy_stays", value_busy, 1);
        step(); step();
        chk("sim_shown", font_char, 8'h31);
        vsync_in = 1'b0; step(); vsync_in = 1'b1;
        chk("sim_busy_clr", value_busy, 0);
        step();
        chk("sim_pending", font_char, 8'h32);
        value = 16'hABCD; value_load = 1'b1; set(1'b0, 1'b1, 1'b1, 10'd300, 10'd260); step(); value_load = 1'b0;
        step(); step(); step();
        chk("pre_rst_rgb", rgb, 3'b010); chk("pre_rst_hsync", hsync, 0); chk("pre_rst_busy", value_busy, 1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_hsync", hsync, 1); chk("arst_vsync", vsync, 1); chk("arst_rgb", rgb, 0);
        chk("arst_busy", value_busy, 0); chk("arst_char", font_char, 0);
        @(negedge px_clk) resetn = 1'b1;
        step(); step();
        chk("post_rst_char", font_char, 8'h30);
        step();
        chk("post_rst_lag_rgb", rgb, 0); chk("post_rst_lag_hsync", hsync, 1);
        step();
        chk("post_rst_rgb", rgb, 3'b010); chk("post_rst_hsync", hsync, 0); chk("post_rst_busy", value_busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
